// File: rtl/ref_bank_pkg.sv
// ref_bank_pkg
//   Shared defaults for the reference-pixel bank array and the ME top:
//   pixel geometry, the word type, default bank geometry, and a helper
//   that sizes an index field so it never collapses to zero bits.
package ref_bank_pkg;

    localparam int PIX_W_DEF    = 8;
    localparam int PIX_NUM_DEF  = 8;
    localparam int WORD_W_DEF   = PIX_W_DEF * PIX_NUM_DEF;

    localparam int DEPTH_DEF    = 96;
    localparam int NUM_BANK_DEF = 4;
    localparam int SEG_LEN_DEF  = 24;

    typedef logic [WORD_W_DEF-1:0] word_t;

    // Width of an index into n items, at least 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ref_bank_ram.sv
// ref_bank_ram
//   One reference-pixel bank: DEPTH x W, one write port and one registered
//   read port on the same clock. A read and a write to the same address in
//   the same cycle return the old contents (read-before-write). The read
//   register only updates when re_i is high, so the last word is held.
//   Drop-in replaceable by a RAM macro with the same behaviour.
//
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read address (must be < DEPTH when re_i is high)
//   rdata_o  out  registered read data
module ref_bank_ram #(
    parameter int DEPTH = 96,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto plain RAM; a
    // reset loop here would force thousands of flops instead.
    // NOTE: non-blocking assignments make the read sample mem_q before
    // this edge's write lands, which is exactly read-before-write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ref_bank_array.sv
// ref_bank_array
//   Multi-bank reference-pixel store for the ME datapath. Incoming words are
//   written round-robin across NUM_BANK banks in segments of SEG_LEN words;
//   every bank keeps its own write pointer that wraps at DEPTH. A random
//   access read port returns registered data one cycle after rd_en.
//
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   flush     in   synchronous clear of pointers/counters (beats wr_en)
//   wr_en     in   write strobe
//   wr_data   in   write word
//   rd_en     in   read request
//   rd_bank   in   bank to read
//   rd_addr   in   word address within the bank
//   rd_data   out  read word (0 after reset or an out-of-range read)
//   rd_valid  out  rd_data valid, one cycle after rd_en
//   rd_err    out  out-of-range read flag, aligned with rd_valid
//   wr_bank   out  bank taking the next write
//   wr_ptr    out  address the next write goes to
//   seg_done  out  one-cycle pulse after the last write of a segment
//   lap_done  out  one-cycle pulse after a bank pointer wraps
module ref_bank_array
    import ref_bank_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int PIX_NUM  = PIX_NUM_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_BANK = NUM_BANK_DEF,
    parameter int SEG_LEN  = SEG_LEN_DEF,
    parameter int AW       = $clog2(DEPTH),
    parameter int BW       = idx_width(NUM_BANK),
    localparam int W       = PIX_W * PIX_NUM
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [BW-1:0] rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic          rd_err,
    output logic [BW-1:0] wr_bank,
    output logic [AW-1:0] wr_ptr,
    output logic          seg_done,
    output logic          lap_done
);

    localparam int CW = idx_width(SEG_LEN);

    // Write sequencer state
    logic [AW-1:0] wrp_q [NUM_BANK];
    logic [CW-1:0] seg_cnt_q;
    logic [BW-1:0] wr_bank_q;
    logic          seg_done_q;
    logic          lap_done_q;

    // Read path state
    logic          rd_valid_q;
    logic          rd_err_q;
    logic          rd_zero_q;   // force rd_data to 0 (after reset / bad read)
    logic [BW-1:0] rd_bank_q;   // bank whose read register drives rd_data

    logic [W-1:0]  ram_rdata [NUM_BANK];
    logic          wr_fire;
    logic          rd_bad;
    logic [AW-1:0] wrp_cur;
    logic          wrp_last;
    logic          seg_last;
    logic [AW-1:0] wrp_d;
    logic [CW-1:0] seg_cnt_d;
    logic [BW-1:0] wr_bank_d;

    assign wr_fire  = wr_en & ~flush;
    assign wrp_cur  = wrp_q[wr_bank_q];
    assign wrp_last = (wrp_cur == AW'(DEPTH - 1));
    assign seg_last = (seg_cnt_q == CW'(SEG_LEN - 1));

    // Out-of-range bank is rejected too, so a non power-of-two NUM_BANK
    // can never select a missing read register.
    assign rd_bad = ({1'b0, rd_addr} >= (AW + 1)'(DEPTH)) |
                    ({1'b0, rd_bank} >= (BW + 1)'(NUM_BANK));

    // NOTE: every output of this block gets a value on every path so no
    // latch is inferred.
    always_comb begin
        wrp_d     = wrp_last ? '0 : wrp_cur + 1'b1;
        seg_cnt_d = seg_last ? '0 : seg_cnt_q + 1'b1;
        wr_bank_d = wr_bank_q;
        if (seg_last) begin
            wr_bank_d = (wr_bank_q == BW'(NUM_BANK - 1)) ? '0 : wr_bank_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                wrp_q[b] <= '0;
            end
            seg_cnt_q  <= '0;
            wr_bank_q  <= '0;
            seg_done_q <= 1'b0;
            lap_done_q <= 1'b0;
        end else begin
            seg_done_q <= 1'b0;
            lap_done_q <= 1'b0;
            if (flush) begin
                for (int b = 0; b < NUM_BANK; b++) begin
                    wrp_q[b] <= '0;
                end
                seg_cnt_q <= '0;
                wr_bank_q <= '0;
            end else if (wr_en) begin
                wrp_q[wr_bank_q] <= wrp_d;
                seg_cnt_q        <= seg_cnt_d;
                wr_bank_q        <= wr_bank_d;
                lap_done_q       <= wrp_last;
                seg_done_q       <= seg_last;
            end
        end
    end

    // Flush does not touch the read path, so an in-flight read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
            rd_bank_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            rd_err_q   <= rd_en & rd_bad;
            if (rd_en) begin
                rd_zero_q <= rd_bad;
                if (!rd_bad) begin
                    rd_bank_q <= rd_bank;
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        ref_bank_ram #(
            .DEPTH (DEPTH),
            .W     (W),
            .AW    (AW)
        ) u_ram (
            .clk     (clk),
            .we_i    (wr_fire && (wr_bank_q == BW'(b))),
            .waddr_i (wrp_q[b]),
            .wdata_i (wr_data),
            .re_i    (rd_en && !rd_bad && (rd_bank == BW'(b))),
            .raddr_i (rd_addr),
            .rdata_o (ram_rdata[b])
        );
    end

    // Only the selected bank's read register loads, so the mux output holds
    // its last value while rd_en is low.
    assign rd_data  = rd_zero_q ? '0 : ram_rdata[rd_bank_q];
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_bank  = wr_bank_q;
    assign wr_ptr   = wrp_cur;
    assign seg_done = seg_done_q;
    assign lap_done = lap_done_q;

endmodule

// File: tb/tb_ref_bank_array.sv
// Bench for ref_bank_array: directed scenarios plus a randomized run, all
// scored against a word-count model (bank = segment index mod NUM_BANK,
// address = writes seen by that bank mod DEPTH).
module tb_ref_bank_array;
    import ref_bank_pkg::*;

    localparam int NB = 4;
    localparam int DP = 96;
    localparam int SL = 24;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        flush   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [63:0] wr_data = '0;
    logic        rd_en   = 1'b0;
    logic [1:0]  rd_bank = '0;
    logic [6:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        rd_valid, rd_err, seg_done, lap_done;
    logic [1:0]  wr_bank;
    logic [6:0]  wr_ptr;

    // Second instance with DEPTH=90 for the range check
    logic        r90_flush   = 1'b0;
    logic        r90_wr_en   = 1'b0;
    logic [63:0] r90_wr_data = '0;
    logic        r90_rd_en   = 1'b0;
    logic [1:0]  r90_rd_bank = '0;
    logic [6:0]  r90_rd_addr = '0;
    logic [63:0] r90_rd_data;
    logic        r90_rd_valid, r90_rd_err, r90_seg_done, r90_lap_done;
    logic [1:0]  r90_wr_bank;
    logic [6:0]  r90_wr_ptr;

    always #5 clk = ~clk;

    ref_bank_array dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err), .wr_bank(wr_bank), .wr_ptr(wr_ptr),
        .seg_done(seg_done), .lap_done(lap_done)
    );

    ref_bank_array #(.DEPTH(90)) dut90 (
        .clk(clk), .rst_n(rst_n), .flush(r90_flush), .wr_en(r90_wr_en), .wr_data(r90_wr_data),
        .rd_en(r90_rd_en), .rd_bank(r90_rd_bank), .rd_addr(r90_rd_addr), .rd_data(r90_rd_data),
        .rd_valid(r90_rd_valid), .rd_err(r90_rd_err), .wr_bank(r90_wr_bank), .wr_ptr(r90_wr_ptr),
        .seg_done(r90_seg_done), .lap_done(r90_lap_done)
    );

    // Reference model
    int          wcount;
    int          bank_cnt [NB];
    logic [63:0] mem_m    [NB][DP];
    bit          known_m  [NB][DP];
    logic [63:0] last_rd;
    bit          last_known;
    int          lap_seen;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int m_bank();
        return (wcount / SL) % NB;
    endfunction

    function automatic int m_ptr();
        return bank_cnt[m_bank()] % DP;
    endfunction

    task automatic model_clear_ptrs();
        wcount = 0;
        for (int b = 0; b < NB; b++) bank_cnt[b] = 0;
    endtask

    // Drive one cycle on the default instance and score every output.
    task automatic step(input bit we, input logic [63:0] wd, input bit re,
                        input int rb, input int ra, input string tag);
        bit exp_seg, exp_lap;
        int b, a;
        wr_en = we; wr_data = wd; rd_en = re; flush = 1'b0;
        rd_bank = 2'(rb); rd_addr = 7'(ra);
        exp_seg = 1'b0; exp_lap = 1'b0;
        if (re) begin
            last_rd    = mem_m[rb][ra];
            last_known = known_m[rb][ra];
        end
        if (we) begin
            b = m_bank(); a = m_ptr();
            mem_m[b][a] = wd; known_m[b][a] = 1'b1;
            wcount++; bank_cnt[b]++;
            exp_seg = (wcount % SL) == 0;
            exp_lap = (bank_cnt[b] % DP) == 0;
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        if (lap_done === 1'b1) lap_seen++;
        n_checks++;
        if (rd_valid !== re) $display("FAIL %s rd_valid: got %b expected %b", tag, rd_valid, re);
        else n_pass++;
        n_checks++;
        if (rd_err !== 1'b0) $display("FAIL %s rd_err: got %b expected 0", tag, rd_err);
        else n_pass++;
        if (last_known) begin
            n_checks++;
            if (rd_data !== last_rd) $display("FAIL %s rd_data: got %h expected %h", tag, rd_data, last_rd);
            else n_pass++;
        end
        n_checks++;
        if (seg_done !== exp_seg) $display("FAIL %s seg_done: got %b expected %b", tag, seg_done, exp_seg);
        else n_pass++;
        n_checks++;
        if (lap_done !== exp_lap) $display("FAIL %s lap_done: got %b expected %b", tag, lap_done, exp_lap);
        else n_pass++;
        n_checks++;
        if (wr_bank !== 2'(m_bank())) $display("FAIL %s wr_bank: got %0d expected %0d", tag, wr_bank, m_bank());
        else n_pass++;
        n_checks++;
        if (wr_ptr !== 7'(m_ptr())) $display("FAIL %s wr_ptr: got %0d expected %0d", tag, wr_ptr, m_ptr());
        else n_pass++;
    endtask

    // One flush cycle, optionally with a write that must be dropped.
    task automatic do_flush(input bit we, input logic [63:0] wd);
        flush = 1'b1; wr_en = we; wr_data = wd; rd_en = 1'b0;
        model_clear_ptrs();
        @(posedge clk); #1;
        flush = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (wr_bank !== 2'd0) $display("FAIL flush wr_bank: got %0d expected 0", wr_bank);
        else n_pass++;
        n_checks++;
        if (wr_ptr !== 7'd0) $display("FAIL flush wr_ptr: got %0d expected 0", wr_ptr);
        else n_pass++;
        n_checks++;
        if (seg_done !== 1'b0 || lap_done !== 1'b0)
            $display("FAIL flush pulses: got seg=%b lap=%b expected 0/0", seg_done, lap_done);
        else n_pass++;
        n_checks++;
        if (rd_valid !== 1'b0) $display("FAIL flush rd_valid: got %b expected 0", rd_valid);
        else n_pass++;
    endtask

    task automatic release_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_clear_ptrs();
        last_rd = '0; last_known = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        n_checks++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || rd_err !== 1'b0)
            $display("FAIL %s read outs: got data=%h valid=%b err=%b expected 0/0/0", tag, rd_data, rd_valid, rd_err);
        else n_pass++;
        n_checks++;
        if (wr_bank !== 2'd0 || wr_ptr !== 7'd0 || seg_done !== 1'b0 || lap_done !== 1'b0)
            $display("FAIL %s write outs: got bank=%0d ptr=%0d seg=%b lap=%b expected 0", tag, wr_bank, wr_ptr, seg_done, lap_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_zero_outputs("reset");
        release_reset();
    endtask

    task automatic test_segment();
        rst_n = 1'b0; #2;
        release_reset();
        for (int i = 0; i < SL; i++) step(1'b1, 64'(i), 1'b0, 0, 0, "seg_wr");
        n_checks++;
        if (seg_done !== 1'b1) $display("FAIL seg_done_after_24: got %b expected 1", seg_done);
        else n_pass++;
        n_checks++;
        if (wr_bank !== 2'd1 || wr_ptr !== 7'd0)
            $display("FAIL seg_next_pos: got bank=%0d ptr=%0d expected 1/0", wr_bank, wr_ptr);
        else n_pass++;
        step(1'b0, '0, 1'b1, 0, 5, "seg_rd");
        n_checks++;
        if (rd_data !== 64'd5 || rd_valid !== 1'b1)
            $display("FAIL seg_read_b0a5: got %h valid=%b expected 5 valid=1", rd_data, rd_valid);
        else n_pass++;
    endtask

    task automatic test_full_lap();
        rst_n = 1'b0; #2;
        release_reset();
        lap_seen = 0;
        for (int i = 0; i < NB * DP; i++) step(1'b1, 64'(i), 1'b0, 0, 0, "lap_wr");
        n_checks++;
        if (lap_seen !== 4) $display("FAIL lap_count: got %0d expected 4", lap_seen);
        else n_pass++;
        n_checks++;
        if (wr_bank !== 2'd0 || wr_ptr !== 7'd0)
            $display("FAIL lap_end_pos: got bank=%0d ptr=%0d expected 0/0", wr_bank, wr_ptr);
        else n_pass++;
        step(1'b0, '0, 1'b1, 1, 24, "lap_rd_b1");
        n_checks++;
        if (rd_data !== 64'd120) $display("FAIL lap_b1a24: got %0d expected 120", rd_data);
        else n_pass++;
        step(1'b0, '0, 1'b1, 2, 24, "lap_rd_b2");
        n_checks++;
        if (rd_data !== 64'd144) $display("FAIL lap_b2a24: got %0d expected 144", rd_data);
        else n_pass++;
    endtask

    task automatic test_read_before_write();
        logic [63:0] aa, bb;
        aa = {8{8'hAA}}; bb = {8{8'hBB}};
        do_flush(1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 64'(i + 1000), 1'b0, 0, 0, "rbw_fill");
        step(1'b1, aa, 1'b0, 0, 0, "rbw_wr_aa");
        do_flush(1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 64'(i + 2000), 1'b0, 0, 0, "rbw_fill2");
        step(1'b1, bb, 1'b1, 0, 3, "rbw_collide");
        n_checks++;
        if (rd_data !== aa) $display("FAIL rbw_old_data: got %h expected %h", rd_data, aa);
        else n_pass++;
        step(1'b0, '0, 1'b1, 0, 3, "rbw_reread");
        n_checks++;
        if (rd_data !== bb) $display("FAIL rbw_new_data: got %h expected %h", rd_data, bb);
        else n_pass++;
    endtask

    task automatic test_flush();
        rst_n = 1'b0; #2;
        release_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 64'(256 + i), 1'b0, 0, 0, "fl_wr");
        do_flush(1'b1, 64'hDEAD_BEEF_0000_0001);
        step(1'b0, '0, 1'b0, 0, 0, "fl_idle");
        step(1'b0, '0, 1'b1, 0, 9, "fl_rd9");
        n_checks++;
        if (rd_data !== 64'd265) $display("FAIL flush_keeps_data: got %h expected %h", rd_data, 64'd265);
        else n_pass++;
        // addr 10 must still hold what the model last wrote there
        step(1'b0, '0, 1'b1, 0, 10, "fl_rd10_dropped");
    endtask

    task automatic test_range();
        logic [63:0] v;
        v = {$urandom, $urandom};
        r90_wr_en = 1'b1; r90_wr_data = v;
        @(posedge clk); #1;
        r90_wr_en = 1'b0;
        n_checks++;
        if (r90_wr_ptr !== 7'd1 || r90_wr_bank !== 2'd0 || r90_seg_done !== 1'b0 || r90_lap_done !== 1'b0)
            $display("FAIL r90_write: got ptr=%0d bank=%0d seg=%b lap=%b expected 1/0/0/0", r90_wr_ptr, r90_wr_bank, r90_seg_done, r90_lap_done);
        else n_pass++;
        r90_rd_en = 1'b1; r90_rd_bank = 2'd0; r90_rd_addr = 7'd0;
        @(posedge clk); #1;
        n_checks++;
        if (r90_rd_data !== v || r90_rd_err !== 1'b0 || r90_rd_valid !== 1'b1)
            $display("FAIL r90_rd0: got %h err=%b valid=%b expected %h 0 1", r90_rd_data, r90_rd_err, r90_rd_valid, v);
        else n_pass++;
        r90_rd_addr = 7'd95;
        @(posedge clk); #1;
        r90_rd_en = 1'b0;
        n_checks++;
        if (r90_rd_err !== 1'b1 || r90_rd_valid !== 1'b1 || r90_rd_data !== '0)
            $display("FAIL r90_rd95: got err=%b valid=%b data=%h expected 1 1 0", r90_rd_err, r90_rd_valid, r90_rd_data);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (r90_rd_err !== 1'b0 || r90_rd_valid !== 1'b0 || r90_rd_data !== '0)
            $display("FAIL r90_idle: got err=%b valid=%b data=%h expected 0 0 0", r90_rd_err, r90_rd_valid, r90_rd_data);
        else n_pass++;
        r90_rd_en = 1'b1; r90_rd_addr = 7'd89;
        @(posedge clk); #1;
        r90_rd_en = 1'b0;
        n_checks++;
        if (r90_rd_err !== 1'b0 || r90_rd_valid !== 1'b1)
            $display("FAIL r90_rd89: got err=%b valid=%b expected 0 1", r90_rd_err, r90_rd_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] x;
        rst_n = 1'b0; #2;
        release_reset();
        for (int i = 0; i < 12; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 0, 0, "mid_wr");
        step(1'b1, {$urandom, $urandom}, 1'b1, 0, 2, "mid_wr13");
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        release_reset();
        x = {$urandom, $urandom};
        step(1'b1, x, 1'b0, 0, 0, "mid_first_wr");
        step(1'b0, '0, 1'b1, 0, 0, "mid_rd");
        n_checks++;
        if (rd_data !== x) $display("FAIL mid_first_at_b0a0: got %h expected %h", rd_data, x);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_flush(1'($urandom_range(0, 1)), {$urandom, $urandom});
            end else begin
                step(($urandom_range(0, 9) < 7), {$urandom, $urandom},
                     1'($urandom_range(0, 1)), int'($urandom_range(0, NB - 1)),
                     int'($urandom_range(0, DP - 1)), "rand");
            end
        end
    endtask

    initial begin
        model_clear_ptrs();
        last_rd = '0; last_known = 1'b1; lap_seen = 0;
        test_reset();
        test_segment();
        test_full_lap();
        test_read_before_write();
        test_flush();
        test_range();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
